// File: rtl/aq_biu_write_channel_pkg.sv
// Shared BIU write-channel definitions: widths, AXI encodings, credit limits and
// the buffered AW/W payload layouts.
package aq_biu_write_channel_pkg;

  localparam int unsigned PADDR       = 40;
  localparam int unsigned ID_W        = 4;
  localparam int unsigned PAD_ID_W    = 8;
  localparam int unsigned LEN_W       = 2;
  localparam int unsigned PAD_LEN_W   = 8;
  localparam int unsigned DATA_W      = 128;
  localparam int unsigned STRB_W      = 16;
  localparam int unsigned AW_CRED_MAX = 4;
  localparam int unsigned CRED_W      = 3;
  localparam int unsigned OUTST_W     = 4;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef struct packed {
    logic [PADDR-1:0]     addr;
    logic [PAD_ID_W-1:0]  id;
    logic [PAD_LEN_W-1:0] len;
    logic [2:0]           size;
    logic [1:0]           burst;
    logic [3:0]           cache;
    logic [2:0]           prot;
    logic                 lock;
  } aw_pld_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
    logic              last;
  } w_pld_t;

  function automatic logic [PAD_ID_W-1:0] zext_id(input logic [ID_W-1:0] id);
    return {{(PAD_ID_W-ID_W){1'b0}}, id};
  endfunction

  function automatic logic [PAD_LEN_W-1:0] zext_len(input logic [LEN_W-1:0] len);
    return {{(PAD_LEN_W-LEN_W){1'b0}}, len};
  endfunction

endpackage

// File: rtl/aq_biu_write_channel_if.sv
// Internal AW/W/B request side and AXI pad side of the BIU write channel.
// slave = the write channel itself, master = upstream LSU plus pad environment.
interface aq_biu_write_channel_if;
  import aq_biu_write_channel_pkg::*;

  logic                 awvalid;
  logic                 awready;
  logic [PADDR-1:0]     awaddr;
  logic [ID_W-1:0]      awid;
  logic [LEN_W-1:0]     awlen;
  logic [2:0]           awsize;
  logic [1:0]           awburst;
  logic [3:0]           awcache;
  logic [2:0]           awprot;
  logic                 awlock;
  logic                 wvalid;
  logic                 wready;
  logic [DATA_W-1:0]    wdata;
  logic [STRB_W-1:0]    wstrb;
  logic                 wlast;
  logic                 bvalid;
  logic [ID_W-1:0]      bid;
  logic [1:0]           bresp;

  logic                 biu_pad_awvalid;
  logic [PADDR-1:0]     biu_pad_awaddr;
  logic [PAD_ID_W-1:0]  biu_pad_awid;
  logic [PAD_LEN_W-1:0] biu_pad_awlen;
  logic [2:0]           biu_pad_awsize;
  logic [1:0]           biu_pad_awburst;
  logic [3:0]           biu_pad_awcache;
  logic [2:0]           biu_pad_awprot;
  logic                 biu_pad_awlock;
  logic                 pad_biu_awready;
  logic                 biu_pad_wvalid;
  logic [DATA_W-1:0]    biu_pad_wdata;
  logic [STRB_W-1:0]    biu_pad_wstrb;
  logic                 biu_pad_wlast;
  logic                 pad_biu_wready;
  logic                 pad_biu_bvalid;
  logic [PAD_ID_W-1:0]  pad_biu_bid;
  logic [1:0]           pad_biu_bresp;
  logic                 biu_pad_bready;

  modport slave (
    input  awvalid, awaddr, awid, awlen, awsize, awburst, awcache, awprot, awlock,
    input  wvalid, wdata, wstrb, wlast,
    input  pad_biu_awready, pad_biu_wready, pad_biu_bvalid, pad_biu_bid, pad_biu_bresp,
    output awready, wready, bvalid, bid, bresp,
    output biu_pad_awvalid, biu_pad_awaddr, biu_pad_awid, biu_pad_awlen, biu_pad_awsize,
    output biu_pad_awburst, biu_pad_awcache, biu_pad_awprot, biu_pad_awlock,
    output biu_pad_wvalid, biu_pad_wdata, biu_pad_wstrb, biu_pad_wlast, biu_pad_bready
  );

  modport master (
    output awvalid, awaddr, awid, awlen, awsize, awburst, awcache, awprot, awlock,
    output wvalid, wdata, wstrb, wlast,
    output pad_biu_awready, pad_biu_wready, pad_biu_bvalid, pad_biu_bid, pad_biu_bresp,
    input  awready, wready, bvalid, bid, bresp,
    input  biu_pad_awvalid, biu_pad_awaddr, biu_pad_awid, biu_pad_awlen, biu_pad_awsize,
    input  biu_pad_awburst, biu_pad_awcache, biu_pad_awprot, biu_pad_awlock,
    input  biu_pad_wvalid, biu_pad_wdata, biu_pad_wstrb, biu_pad_wlast, biu_pad_bready
  );

endinterface

// File: rtl/aq_biu_write_channel_skid_buf1.sv
// aq_biu_skid_buf1: one-entry valid/payload holding register; a create in the
// same cycle as a pop reloads the entry and keeps it valid.
module aq_biu_skid_buf1
  import aq_biu_write_channel_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         biu_clk,
  input  logic         cpurst_b,
  input  logic         create,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         vld,
  output logic [W-1:0] dout
);

  logic         vld_q;
  logic         vld_d;
  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (create) begin
      vld_d  = 1'b1;
      data_d = din;
    end else if (pop) begin
      vld_d  = 1'b0;
    end else begin
      vld_d  = vld_q;
    end
  end

  always_ff @(posedge biu_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      vld_q  <= 1'b0;
      data_q <= {W{1'b0}};
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign vld  = vld_q;
  assign dout = data_q;

endmodule

// File: rtl/aq_biu_write_channel.sv
// BIU AXI write channel: AW/W pad buffers, AW-ahead-of-W credit and B pulse.
// AQ_BIU_WRITE_OUTST_CNT_EN adds an outstanding-write counter to write_idle.
module aq_biu_write_channel
  import aq_biu_write_channel_pkg::*;
(
  input  logic                  biu_clk,
  input  logic                  cpurst_b,
  input  logic                  axim_clk_en,
  aq_biu_write_channel_if.slave bus,
  output logic                  write_idle,
  output logic                  write_channel_clk_en
);

  localparam logic [CRED_W-1:0] CRED_FULL = 3'd4;

  aw_pld_t           aw_din_s;
  aw_pld_t           aw_dout_s;
  w_pld_t            w_din_s;
  w_pld_t            w_dout_s;
  logic              aw_vld_s;
  logic              w_vld_s;
  logic              aw_ready_s;
  logic              w_ready_s;
  logic              aw_create_s;
  logic              aw_pop_s;
  logic              w_create_s;
  logic              w_pop_s;
  logic              b_create_s;
  logic              outst_ok_s;
  logic              idle_cnt_s;
  logic              bid_hi_unused_s;
  logic [CRED_W-1:0] cred_q;
  logic [CRED_W-1:0] cred_d;
  logic              bvalid_q;
  logic              bvalid_d;
  logic [ID_W-1:0]   bid_q;
  logic [ID_W-1:0]   bid_d;
  logic [1:0]        bresp_q;
  logic [1:0]        bresp_d;

  // Handshakes: W needs an AW credit, either banked or arriving this cycle.
  always_comb begin
    aw_ready_s  = (~aw_vld_s | bus.pad_biu_awready) & axim_clk_en
                & (cred_q != CRED_FULL) & outst_ok_s;
    aw_create_s = bus.awvalid & aw_ready_s;
    aw_pop_s    = aw_vld_s & bus.pad_biu_awready & axim_clk_en;
    w_ready_s   = (~w_vld_s | bus.pad_biu_wready) & axim_clk_en
                & ((cred_q != 3'd0) | aw_create_s);
    w_create_s  = bus.wvalid & w_ready_s;
    w_pop_s     = w_vld_s & bus.pad_biu_wready & axim_clk_en;
    b_create_s  = axim_clk_en & bus.pad_biu_bvalid;
  end

  always_comb begin
    aw_din_s.addr  = bus.awaddr;
    aw_din_s.id    = zext_id(bus.awid);
    aw_din_s.len   = zext_len(bus.awlen);
    aw_din_s.size  = bus.awsize;
    aw_din_s.burst = bus.awburst;
    aw_din_s.cache = bus.awcache;
    aw_din_s.prot  = bus.awprot;
    aw_din_s.lock  = bus.awlock;
    w_din_s.data   = bus.wdata;
    w_din_s.strb   = bus.wstrb;
    w_din_s.last   = bus.wlast;
  end

  aq_biu_skid_buf1 #(.W($bits(aw_pld_t))) u_aw_buf (
    .biu_clk  (biu_clk),
    .cpurst_b (cpurst_b),
    .create   (aw_create_s),
    .pop      (aw_pop_s),
    .din      (aw_din_s),
    .vld      (aw_vld_s),
    .dout     (aw_dout_s)
  );

  aq_biu_skid_buf1 #(.W($bits(w_pld_t))) u_w_buf (
    .biu_clk  (biu_clk),
    .cpurst_b (cpurst_b),
    .create   (w_create_s),
    .pop      (w_pop_s),
    .din      (w_din_s),
    .vld      (w_vld_s),
    .dout     (w_dout_s)
  );

  always_comb begin
    cred_d = cred_q;
    case ({aw_create_s, w_create_s & bus.wlast})
      2'b10:   cred_d = cred_q + 3'd1;
      2'b01:   cred_d = cred_q - 3'd1;
      default: cred_d = cred_q;
    endcase
  end

  always_comb begin
    bvalid_d = b_create_s;
    if (b_create_s) begin
      bid_d   = bus.pad_biu_bid[ID_W-1:0];
      bresp_d = bus.pad_biu_bresp;
    end else begin
      bid_d   = bid_q;
      bresp_d = bresp_q;
    end
  end

  always_ff @(posedge biu_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      cred_q   <= 3'd0;
      bvalid_q <= 1'b0;
      bid_q    <= 4'd0;
      bresp_q  <= 2'd0;
    end else begin
      cred_q   <= cred_d;
      bvalid_q <= bvalid_d;
      bid_q    <= bid_d;
      bresp_q  <= bresp_d;
    end
  end

`ifdef AQ_BIU_WRITE_OUTST_CNT_EN
  logic [OUTST_W-1:0] outst_q;
  logic [OUTST_W-1:0] outst_d;

  // Saturating count of pad AWs still waiting for their B.
  always_comb begin
    outst_d = outst_q;
    case ({aw_pop_s, b_create_s})
      2'b10: begin
        if (outst_q != 4'd15) outst_d = outst_q + 4'd1;
        else                  outst_d = outst_q;
      end
      2'b01: begin
        if (outst_q != 4'd0) outst_d = outst_q - 4'd1;
        else                 outst_d = outst_q;
      end
      default: outst_d = outst_q;
    endcase
  end

  always_ff @(posedge biu_clk or negedge cpurst_b) begin
    if (!cpurst_b) outst_q <= 4'd0;
    else           outst_q <= outst_d;
  end

  assign outst_ok_s = (outst_q != 4'd15);
  assign idle_cnt_s = (outst_q == 4'd0);
`else
  assign outst_ok_s = 1'b1;
  assign idle_cnt_s = 1'b1;
`endif

  assign bid_hi_unused_s = ^bus.pad_biu_bid[PAD_ID_W-1:ID_W];

  assign bus.awready         = aw_ready_s;
  assign bus.wready          = w_ready_s;
  assign bus.bvalid          = bvalid_q;
  assign bus.bid             = bid_q;
  assign bus.bresp           = bresp_q;
  assign bus.biu_pad_awvalid = aw_vld_s;
  assign bus.biu_pad_awaddr  = aw_dout_s.addr;
  assign bus.biu_pad_awid    = aw_dout_s.id;
  assign bus.biu_pad_awlen   = aw_dout_s.len;
  assign bus.biu_pad_awsize  = aw_dout_s.size;
  assign bus.biu_pad_awburst = aw_dout_s.burst;
  assign bus.biu_pad_awcache = aw_dout_s.cache;
  assign bus.biu_pad_awprot  = aw_dout_s.prot;
  assign bus.biu_pad_awlock  = aw_dout_s.lock;
  assign bus.biu_pad_wvalid  = w_vld_s;
  assign bus.biu_pad_wdata   = w_dout_s.data;
  assign bus.biu_pad_wstrb   = w_dout_s.strb;
  assign bus.biu_pad_wlast   = w_dout_s.last;
  assign bus.biu_pad_bready  = 1'b1;

  assign write_idle = idle_cnt_s & ~aw_vld_s & ~w_vld_s;
  // bvalid_q is included so the clearing edge of the B pulse is never gated off.
  assign write_channel_clk_en = aw_create_s | aw_pop_s | w_create_s | w_pop_s
                              | b_create_s | bvalid_q;

endmodule

// File: tb/tb_aq_biu_write_channel.sv
// Self-checking bench for aq_biu_write_channel: cycle vector table with AW/W
// scoreboards, then B-path, clock-ratio, write_idle and async-reset sequences.
module tb_aq_biu_write_channel;
  import aq_biu_write_channel_pkg::*;

`ifdef AQ_BIU_WRITE_OUTST_CNT_EN
  localparam bit OUTST_EN = 1'b1;
`else
  localparam bit OUTST_EN = 1'b0;
`endif

  logic biu_clk = 1'b0;
  logic cpurst_b;
  logic axim_clk_en;
  logic write_idle;
  logic write_channel_clk_en;

  aq_biu_write_channel_if bus_if ();

  aq_biu_write_channel dut (
    .biu_clk              (biu_clk),
    .cpurst_b             (cpurst_b),
    .axim_clk_en          (axim_clk_en),
    .bus                  (bus_if),
    .write_idle           (write_idle),
    .write_channel_clk_en (write_channel_clk_en)
  );

  initial forever #5 biu_clk = ~biu_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge biu_clk);
    #1;
  endtask

  task automatic idle_inputs();
    axim_clk_en            = 1'b1;
    bus_if.awvalid         = 1'b0;
    bus_if.awaddr          = 40'h0;
    bus_if.awid            = 4'h0;
    bus_if.awlen           = 2'd0;
    bus_if.awsize          = 3'd4;
    bus_if.awburst         = BURST_INCR;
    bus_if.awcache         = 4'h0;
    bus_if.awprot          = 3'd0;
    bus_if.awlock          = 1'b0;
    bus_if.wvalid          = 1'b0;
    bus_if.wdata           = 128'h0;
    bus_if.wstrb           = 16'h0;
    bus_if.wlast           = 1'b0;
    bus_if.pad_biu_awready = 1'b1;
    bus_if.pad_biu_wready  = 1'b1;
    bus_if.pad_biu_bvalid  = 1'b0;
    bus_if.pad_biu_bid     = 8'h00;
    bus_if.pad_biu_bresp   = RESP_OKAY;
  endtask

  task automatic do_reset();
    idle_inputs();
    #2;
    cpurst_b = 1'b0;
    #10;
    cpurst_b = 1'b1;
    tick();
  endtask

  task automatic drive_b(input logic vld, input logic [7:0] id, input logic [1:0] resp);
    bus_if.pad_biu_bvalid = vld;
    bus_if.pad_biu_bid    = id;
    bus_if.pad_biu_bresp  = resp;
  endtask

  typedef struct {
    bit en, awv, awr, wv, wl, wr;
    bit e_awready, e_wready, e_paw, e_pw;
  } vec_t;

  function automatic vec_t mk(input bit en, input bit awv, input bit awr, input bit wv,
                              input bit wl, input bit wr, input bit e_awready,
                              input bit e_wready, input bit e_paw, input bit e_pw);
    vec_t v;
    v.en = en; v.awv = awv; v.awr = awr; v.wv = wv; v.wl = wl; v.wr = wr;
    v.e_awready = e_awready; v.e_wready = e_wready; v.e_paw = e_paw; v.e_pw = e_pw;
    return v;
  endfunction

  vec_t          tbl[32];
  vec_t          v;
  logic [68:0]   aw_sb[$];
  logic [144:0]  w_sb[$];
  logic [68:0]   aw_exp;
  logic [144:0]  w_exp;
  bit            m_aw;
  bit            m_w;
  bit            exp_cken;

  initial begin
    //            en awv awr wv wl wr | awrdy wrdy paw pw
    tbl[0]  = mk(1, 1, 1, 1, 1, 1,  1, 1, 1, 1);  // single write, AW+W same cycle
    tbl[1]  = mk(1, 0, 1, 0, 0, 1,  1, 0, 0, 0);
    tbl[2]  = mk(1, 0, 1, 1, 1, 1,  1, 0, 0, 0);  // W before AW: blocked
    tbl[3]  = mk(1, 1, 1, 1, 1, 1,  1, 1, 1, 1);
    tbl[4]  = mk(1, 0, 1, 0, 0, 1,  1, 0, 0, 0);  // credit back to 0
    for (int k = 5; k <= 8; k++) tbl[k] = mk(1, 1, 1, 0, 0, 1,  1, 1, 1, 0);
    tbl[9]  = mk(1, 1, 1, 0, 0, 1,  0, 1, 0, 0);  // 5th AW refused
    tbl[10] = mk(1, 1, 1, 1, 1, 1,  0, 1, 0, 1);
    tbl[11] = mk(1, 1, 1, 0, 0, 1,  1, 1, 1, 0);  // credit returned
    tbl[12] = mk(1, 0, 1, 1, 1, 1,  0, 1, 0, 1);
    for (int k = 13; k <= 15; k++) tbl[k] = mk(1, 0, 1, 1, 1, 1,  1, 1, 0, 1);
    tbl[16] = mk(1, 0, 1, 1, 1, 1,  1, 0, 0, 0);
    tbl[17] = mk(0, 1, 1, 1, 1, 1,  0, 0, 0, 0);  // en=0: nothing moves
    tbl[18] = mk(1, 1, 1, 1, 1, 1,  1, 1, 1, 1);
    tbl[19] = mk(0, 0, 1, 0, 0, 1,  0, 0, 1, 1);  // en=0: no pop
    tbl[20] = mk(1, 0, 1, 0, 0, 1,  1, 0, 0, 0);
    tbl[21] = mk(1, 1, 0, 0, 0, 1,  1, 1, 1, 0);  // pad AW back-pressure
    for (int k = 22; k <= 26; k++) tbl[k] = mk(1, 1, 0, 0, 0, 1,  0, 1, 1, 0);
    tbl[27] = mk(1, 1, 1, 0, 0, 1,  1, 1, 1, 0);  // pop + create, vld stays 1
    tbl[28] = mk(1, 0, 1, 0, 0, 1,  1, 1, 0, 0);
    tbl[29] = mk(1, 0, 1, 1, 1, 1,  1, 1, 0, 1);
    tbl[30] = mk(1, 0, 1, 1, 1, 1,  1, 1, 0, 1);
    tbl[31] = mk(1, 0, 1, 0, 0, 1,  1, 0, 0, 0);

    cpurst_b = 1'b0;
    idle_inputs();
    #12;
    chk("rst_pad_awvalid", bus_if.biu_pad_awvalid, 0);
    chk("rst_pad_wvalid", bus_if.biu_pad_wvalid, 0);
    chk("rst_bvalid", bus_if.bvalid, 0);
    chk("rst_write_idle", write_idle, 1);
    chk("rst_pad_awaddr", bus_if.biu_pad_awaddr, 0);
    cpurst_b = 1'b1;
    tick();
    chk("bready_const", bus_if.biu_pad_bready, 1);
    chk("idle_clk_en", write_channel_clk_en, 0);

    m_aw = 1'b0;
    m_w  = 1'b0;
    for (int i = 0; i < 32; i++) begin
      v = tbl[i];
      axim_clk_en            = v.en;
      bus_if.awvalid         = v.awv;
      bus_if.awaddr          = 40'h00_8000_0040 + 40'(i) * 40'd64;
      bus_if.awid            = 4'(i);
      bus_if.awlen           = 2'(i);
      bus_if.awcache         = 4'(15 - i);
      bus_if.awprot          = 3'(i);
      bus_if.awlock          = 1'(i);
      bus_if.pad_biu_awready = v.awr;
      bus_if.wvalid          = v.wv;
      bus_if.wdata           = {88'h0, 32'(i), 8'hA5};
      bus_if.wstrb           = 16'hFFFF ^ 16'(i);
      bus_if.wlast           = v.wl;
      bus_if.pad_biu_wready  = v.wr;
      #3;
      chk($sformatf("awready[%0d]", i), bus_if.awready, v.e_awready);
      chk($sformatf("wready[%0d]", i), bus_if.wready, v.e_wready);
      exp_cken = (v.awv & v.e_awready) | (m_aw & v.awr & v.en)
               | (v.wv & v.e_wready) | (m_w & v.wr & v.en);
      chk($sformatf("clk_en[%0d]", i), write_channel_clk_en, exp_cken);
      if (m_aw) begin
        if (aw_sb.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL aw_sb[%0d]: got pad AW entry expected none queued", i);
        end else begin
          chk($sformatf("pad_aw_pld[%0d]", i),
              {bus_if.biu_pad_awaddr, bus_if.biu_pad_awid, bus_if.biu_pad_awlen,
               bus_if.biu_pad_awsize, bus_if.biu_pad_awburst, bus_if.biu_pad_awcache,
               bus_if.biu_pad_awprot, bus_if.biu_pad_awlock}, aw_sb[0]);
          if (v.awr && v.en) void'(aw_sb.pop_front());
        end
      end
      if (m_w) begin
        if (w_sb.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL w_sb[%0d]: got pad W entry expected none queued", i);
        end else begin
          chk($sformatf("pad_w_pld[%0d]", i),
              {bus_if.biu_pad_wdata, bus_if.biu_pad_wstrb, bus_if.biu_pad_wlast}, w_sb[0]);
          if (v.wr && v.en) void'(w_sb.pop_front());
        end
      end
      if (v.awv && v.e_awready) begin
        aw_exp = {bus_if.awaddr, 4'h0, bus_if.awid, 6'h0, bus_if.awlen, 3'd4, BURST_INCR,
                  bus_if.awcache, bus_if.awprot, bus_if.awlock};
        aw_sb.push_back(aw_exp);
      end
      if (v.wv && v.e_wready) begin
        w_exp = {bus_if.wdata, bus_if.wstrb, bus_if.wlast};
        w_sb.push_back(w_exp);
      end
      tick();
      chk($sformatf("pad_awvalid[%0d]", i), bus_if.biu_pad_awvalid, v.e_paw);
      chk($sformatf("pad_wvalid[%0d]", i), bus_if.biu_pad_wvalid, v.e_pw);
      m_aw = v.e_paw;
      m_w  = v.e_pw;
    end
    chk("aw_sb_drained", aw_sb.size(), 0);
    chk("w_sb_drained", w_sb.size(), 0);

    // B path: upper pad id bits dropped, back-to-back pulses, single-cycle pulse.
    do_reset();
    drive_b(1'b1, 8'hF3, RESP_OKAY);
    #3;
    chk("b_clk_en", write_channel_clk_en, 1);
    tick();
    chk("b1_valid", bus_if.bvalid, 1);
    chk("b1_id", bus_if.bid, 4'h3);
    chk("b1_resp", bus_if.bresp, RESP_OKAY);
    drive_b(1'b1, 8'hA9, RESP_EXOKAY);
    tick();
    chk("b2_valid", bus_if.bvalid, 1);
    chk("b2_id", bus_if.bid, 4'h9);
    chk("b2_resp", bus_if.bresp, RESP_EXOKAY);
    drive_b(1'b0, 8'h00, RESP_OKAY);
    tick();
    chk("b_clear", bus_if.bvalid, 0);
    chk("b_idle_clk_en", write_channel_clk_en, 0);

    // pad bvalid held over an en=1 / en=0 pair: one pulse only.
    drive_b(1'b1, 8'h57, RESP_SLVERR);
    tick();
    chk("br_valid", bus_if.bvalid, 1);
    chk("br_id", bus_if.bid, 4'h7);
    chk("br_resp", bus_if.bresp, RESP_SLVERR);
    axim_clk_en = 1'b0;
    tick();
    chk("br_no_second", bus_if.bvalid, 0);
    axim_clk_en = 1'b1;
    drive_b(1'b0, 8'h00, RESP_OKAY);
    tick();
    chk("br_still_low", bus_if.bvalid, 0);

    // Three AWs popped to the pad, then Bs returned one by one.
    do_reset();
    bus_if.awvalid = 1'b1;
    repeat (3) tick();
    bus_if.awvalid = 1'b0;
    tick();
    chk("idle_aw_drained", bus_if.biu_pad_awvalid, 0);
    drive_b(1'b1, 8'h01, RESP_OKAY);
    tick();
    drive_b(1'b1, 8'h02, RESP_OKAY);
    tick();
    drive_b(1'b0, 8'h00, RESP_OKAY);
    tick();
    chk("idle_after_2b", write_idle, OUTST_EN ? 1'b0 : 1'b1);
    drive_b(1'b1, 8'h03, RESP_OKAY);
    tick();
    drive_b(1'b0, 8'h00, RESP_OKAY);
    chk("idle_after_3b", write_idle, 1);

    // Async reset with AW, W and B all in flight.
    bus_if.awvalid         = 1'b1;
    bus_if.wvalid          = 1'b1;
    bus_if.wlast           = 1'b0;
    bus_if.pad_biu_awready = 1'b0;
    bus_if.pad_biu_wready  = 1'b0;
    drive_b(1'b1, 8'h0C, RESP_OKAY);
    tick();
    chk("mid_pad_awvalid", bus_if.biu_pad_awvalid, 1);
    chk("mid_pad_wvalid", bus_if.biu_pad_wvalid, 1);
    chk("mid_bvalid", bus_if.bvalid, 1);
    chk("mid_write_idle", write_idle, 0);
    #2;
    cpurst_b = 1'b0;
    #1;
    chk("arst_pad_awvalid", bus_if.biu_pad_awvalid, 0);
    chk("arst_pad_wvalid", bus_if.biu_pad_wvalid, 0);
    chk("arst_bvalid", bus_if.bvalid, 0);
    chk("arst_write_idle", write_idle, 1);
    idle_inputs();
    #10;
    cpurst_b = 1'b1;
    tick();
    chk("post_rst_idle", write_idle, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
